// File: rtl/riscv_pkg.sv
// Shared RISC-V execute-stage definitions: branch condition encodings,
// instruction alignment mask and the redirect sequencer state type.
package riscv_pkg;

    localparam logic [2:0] B_BEQ  = 3'b000;
    localparam logic [2:0] B_BNE  = 3'b001;
    localparam logic [2:0] B_BLT  = 3'b100;
    localparam logic [2:0] B_BGE  = 3'b101;
    localparam logic [2:0] B_BLTU = 3'b110;
    localparam logic [2:0] B_BGEU = 3'b111;

    // Targets must be 4-byte aligned; bit 0 is already cleared for JALR.
    localparam logic [31:0] INSN_ALIGN_MASK = 32'h0000_0002;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } redir_state_t;

endpackage

// File: rtl/branch_control.sv
// Conditional branch resolution for B-type instructions.
module branch_control
    import riscv_pkg::*;
(
    input  logic [31:0] opr_a,
    input  logic [31:0] opr_b,
    input  logic        is_b_type,
    input  logic [2:0]  funct3,
    output logic        branch_taken
);

    always_comb begin
        branch_taken = 1'b0;
        if (is_b_type) begin
            case (funct3)
                B_BEQ:   branch_taken = (opr_a == opr_b);
                B_BNE:   branch_taken = (opr_a != opr_b);
                B_BLT:   branch_taken = ($signed(opr_a) <  $signed(opr_b));
                B_BGE:   branch_taken = ($signed(opr_a) >= $signed(opr_b));
                B_BLTU:  branch_taken = (opr_a <  opr_b);
                B_BGEU:  branch_taken = (opr_a >= opr_b);
                default: branch_taken = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Execute-stage control-flow sequencer: resolves branches/jumps, issues a
// redirect to fetch over valid/ready, squashes wrong-path work, keeps stats.
module branch_redirect_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_is_b_type,
    input  logic        ex_is_jal,
    input  logic        ex_is_jalr,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_rs1,
    input  logic [31:0] ex_rs2,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    input  logic        redir_ready,
    output logic        squash,
    output logic        misalign,
    output logic [31:0] misalign_addr,
    output logic [31:0] br_count,
    output logic [31:0] br_taken_count
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    redir_state_t state_q, state_d;
    logic [3:0]   flush_cnt_q, flush_cnt_d;
    logic         branch_taken;
    logic         need;
    logic         target_misaligned;
    logic [31:0]  target;

    branch_control u_branch_control (
        .opr_a        (ex_rs1),
        .opr_b        (ex_rs2),
        .is_b_type    (ex_is_b_type),
        .funct3       (ex_funct3),
        .branch_taken (branch_taken)
    );

    assign squash            = (state_q != IDLE);
    assign target            = ex_is_jalr ? ((ex_rs1 + ex_imm) & ~32'h1) : (ex_pc + ex_imm);
    assign target_misaligned = |(target & INSN_ALIGN_MASK);
    assign need              = ex_valid & ~squash & (ex_is_jal | ex_is_jalr | branch_taken);

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            IDLE: begin
                if (need && !target_misaligned) state_d = REQ;
            end
            REQ: begin
                if (redir_ready) begin
                    state_d     = DRAIN;
                    flush_cnt_d = FLUSH_LOAD;
                end
            end
            DRAIN: begin
                if (flush_cnt_q == '0) state_d = IDLE;
                else                   flush_cnt_d = flush_cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // redir_valid is registered from the next state so fetch never sees a
    // combinational path from redir_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            flush_cnt_q    <= '0;
            redir_valid    <= 1'b0;
            redir_pc       <= '0;
            misalign       <= 1'b0;
            misalign_addr  <= '0;
            br_count       <= '0;
            br_taken_count <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            redir_valid <= (state_d == REQ);
            misalign    <= need & target_misaligned;
            if (need && !target_misaligned) redir_pc      <= target;
            if (need && target_misaligned)  misalign_addr <= target;
            if ((state_q == IDLE) && ex_valid && ex_is_b_type) begin
                br_count <= br_count + 32'd1;
                if (branch_taken) br_taken_count <= br_taken_count + 32'd1;
            end
        end
    end

endmodule
